dcache_flush_arbiter: RTL and testbench

DCACHE_FLUSH_ARBITER -- requirements
Module: dcache_flush_arbiter

---
 rtl/ariane_pkg.sv | 15 +
 rtl/counter.sv | 18 +
 rtl/dcache_flush_arbiter.sv | 131 +++++++++++++
 tb/tb_dcache_flush_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg: shared types and default constants for the dcache flush arbiter.
package ariane_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, DONE} flush_arb_state_e;

    localparam int unsigned FlushDrainCycles   = 16;
    localparam int unsigned FlushTimeoutCycles = 1024;

    function automatic int unsigned flush_cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 4) ? 4 : ((w > 32) ? 32 : w);
    endfunction

endpackage

// File: rtl/counter.sv
// counter: saturating up-counter with synchronous clear (clear wins over enable).
module counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             en,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count <= '0;
        else if (clear) count <= '0;
        else if (en && count != '1) count <= count + 1'b1;
    end

endmodule

// File: rtl/dcache_flush_arbiter.sv
// dcache_flush_arbiter: round-robin arbiter serializing fence flushes into one dcache flush + drain.
// Optional flush watchdog enabled by macro FLUSH_ARB_TIMEOUT_EN.
module dcache_flush_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned NumReq        = 3,
    parameter int unsigned DrainCycles   = FlushDrainCycles,
    parameter int unsigned TimeoutCycles = FlushTimeoutCycles,
    localparam int unsigned IdW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] done_o,
    output logic [IdW-1:0]    active_id_o,
    output logic              busy_o,
    output logic              flush_dcache_o,
    input  logic              flush_dcache_ack_i,
    input  logic              cache_busy_i,
    output logic              timeout_o
);

    localparam int unsigned DW = flush_cnt_width(DrainCycles);

    flush_arb_state_e state_q, state_d;
    logic [IdW-1:0]   rr_q, rr_d, id_q, id_d, pick, cand;
    logic             flush_q, flush_d, found, expire;
    logic [DW-1:0]    drain_cnt;
    int               idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NumReq; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            cand = IdW'(idx);
            if (!found && req_i[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    counter #(.Width(DW)) u_drain (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clear (state_q != DRAIN || cache_busy_i),
        .en    (1'b1),
        .count (drain_cnt)
    );

`ifdef FLUSH_ARB_TIMEOUT_EN
    localparam int unsigned TW = flush_cnt_width(TimeoutCycles);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_q;

    counter #(.Width(TW)) u_timeout (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clear (state_q != FLUSH),
        .en    (1'b1),
        .count (tmo_cnt)
    );

    assign expire = state_q == FLUSH && !flush_dcache_ack_i && tmo_cnt == TW'(TimeoutCycles - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tmo_q <= 1'b0;
        else tmo_q <= expire;
    end

    assign timeout_o = tmo_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
    assign expire             = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        flush_d = flush_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = pick;
                    flush_d = 1'b1;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_dcache_ack_i || expire) begin
                    flush_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!cache_busy_i && drain_cnt == DW'(DrainCycles - 1)) state_d = DONE;
            end
            default: begin
                rr_d    = (id_q == IdW'(NumReq - 1)) ? '0 : id_q + 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            flush_q <= flush_d;
        end
    end

    assign done_o         = {NumReq{state_q == DONE}} & (NumReq'(1) << id_q);
    assign active_id_o    = id_q;
    assign busy_o         = state_q != IDLE;
    assign flush_dcache_o = flush_q;

endmodule

// File: tb/tb_dcache_flush_arbiter.sv
// tb_dcache_flush_arbiter: directed self-checking bench for the flush arbiter.
module tb_dcache_flush_arbiter;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [2:0] req;
    logic [2:0] done;
    logic [1:0] active_id;
    logic       busy, flush, ack, cache_busy, timeout;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    dcache_flush_arbiter #(
        .NumReq(3),
        .DrainCycles(16),
        .TimeoutCycles(8)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .req_i             (req),
        .done_o            (done),
        .active_id_o       (active_id),
        .busy_o            (busy),
        .flush_dcache_o    (flush),
        .flush_dcache_ack_i(ack),
        .cache_busy_i      (cache_busy),
        .timeout_o         (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called in an IDLE cycle with the request already applied; ack comes in the third FLUSH cycle.
    task automatic serve(input int id, input bit drop);
        tick;
        chk("grant_flush", 32'(flush), 1);
        chk("grant_id", 32'(active_id), 32'(id));
        chk("grant_busy", 32'(busy), 1);
        tick;
        if (drop) req = 3'b000;
        chk("flush_hold", 32'(flush), 1);
        tick;
        ack = 1'b1;
        chk("flush_ack_cycle", 32'(flush), 1);
        tick;
        ack = 1'b0;
        chk("flush_drop", 32'(flush), 0);
        chk("drain_done", 32'(done), 0);
        repeat (15) begin
            tick;
            chk("drain_done", 32'(done), 0);
        end
        tick;
        chk("done_pulse", 32'(done), 32'(1 << id));
        chk("done_busy", 32'(busy), 1);
        tick;
        chk("idle_done", 32'(done), 0);
        chk("idle_flush", 32'(flush), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        rst_ni     = 1'b0;
        req        = 3'b000;
        ack        = 1'b0;
        cache_busy = 1'b0;
        #2;
        chk("rst_flush", 32'(flush), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_id", 32'(active_id), 0);
        chk("rst_timeout", 32'(timeout), 0);
        tick;
        tick;
        #2 rst_ni = 1'b1;

        // single requester: cycle 0 request, ack in cycle 5, stray ack in DRAIN
        tick;
        req = 3'b001;
        chk("c0_busy", 32'(busy), 0);
        chk("c0_flush", 32'(flush), 0);
        for (int c = 1; c <= 23; c++) begin
            tick;
            if (c == 1) req = 3'b000;
            ack = (c == 5 || c == 10);
            if (c <= 5) chk("single_flush_high", 32'(flush), 1);
            if (c >= 6) chk("single_flush_low", 32'(flush), 0);
            if (c == 1) chk("single_id", 32'(active_id), 0);
            if (c < 22) chk("single_no_done", 32'(done), 0);
            if (c == 22) chk("single_done", 32'(done), 3'b001);
            if (c == 23) chk("single_idle_busy", 32'(busy), 0);
        end
        ack = 1'b0;

        // ack while idle must not start anything
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk("idle_ack_busy", 32'(busy), 0);
        chk("idle_ack_flush", 32'(flush), 0);

        // async reset asserted in DRAIN (rr_ptr is 1 so requester 1 wins)
        req = 3'b010;
        tick;
        req = 3'b000;
        chk("rst_seq_id", 32'(active_id), 1);
        tick;
        ack = 1'b1;
        tick;
        ack = 1'b0;
        tick;
        tick;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_flush", 32'(flush), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_id", 32'(active_id), 0);
        chk("arst_timeout", 32'(timeout), 0);
        tick;
        tick;
        #2 rst_ni = 1'b1;
        repeat (20) begin
            tick;
            chk("arst_no_done", 32'(done), 0);
            chk("arst_idle", 32'(busy), 0);
        end

        // contention: all three held from rr_ptr 0
        req = 3'b111;
        serve(0, 1'b0);
        serve(1, 1'b0);
        serve(2, 1'b0);
        req = 3'b000;
        tick;
        chk("cont_end_busy", 32'(busy), 0);

        // withdrawn request still completes
        req = 3'b010;
        serve(1, 1'b1);

        // drain restart: cache busy in cycles ack+5..ack+7
        req = 3'b100;
        tick;
        req = 3'b000;
        chk("restart_id", 32'(active_id), 2);
        tick;
        ack = 1'b1;
        for (int c = 1; c < 24; c++) begin
            tick;
            ack = 1'b0;
            cache_busy = (c >= 5 && c <= 7);
            chk("restart_wait", 32'(done), 0);
        end
        tick;
        chk("restart_done", 32'(done), 3'b100);
        tick;
        chk("restart_idle", 32'(busy), 0);

        // no ack: watchdog behaviour depends on the build
        req = 3'b001;
        tick;
        req = 3'b000;
        chk("tmo_f1_flush", 32'(flush), 1);
        chk("tmo_f1_timeout", 32'(timeout), 0);
`ifdef FLUSH_ARB_TIMEOUT_EN
        repeat (7) begin
            tick;
            chk("tmo_flush", 32'(flush), 1);
            chk("tmo_quiet", 32'(timeout), 0);
        end
        tick;
        chk("tmo_pulse", 32'(timeout), 1);
        chk("tmo_flush_drop", 32'(flush), 0);
        tick;
        chk("tmo_one_cycle", 32'(timeout), 0);
        repeat (14) begin
            tick;
            chk("tmo_drain", 32'(done), 0);
        end
        tick;
        chk("tmo_done", 32'(done), 3'b001);
`else
        repeat (40) begin
            tick;
            chk("wait_flush", 32'(flush), 1);
            chk("wait_timeout", 32'(timeout), 0);
            chk("wait_busy", 32'(busy), 1);
        end
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk("wait_ack_drop", 32'(flush), 0);
        repeat (15) begin
            tick;
            chk("wait_drain", 32'(done), 0);
        end
        tick;
        chk("wait_done", 32'(done), 3'b001);
`endif
        tick;
        chk("final_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
